// File: rtl/flip_flop_pkg.sv
// Shared defaults and datapath word type for the flip_flop storage element.
package flip_flop_pkg;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_RESET_VALUE = 0;
    localparam int DEFAULT_STAGES      = 1;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/flip_flop_stage.sv
// Single WIDTH-bit register stage with synchronous active-high reset to RESET_VALUE.
module flip_flop_stage
    import flip_flop_pkg::*;
#(
    parameter int                WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/flip_flop.sv
// Width-parameterised synchronously reset D register, STAGES deep.
// Define FLIP_FLOP_ASSERT_EN to compile in simulation-only checks.
module flip_flop
    import flip_flop_pkg::*;
#(
    parameter int                WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE),
    parameter int                STAGES      = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_d [STAGES];
    logic [WIDTH-1:0] stage_q [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign stage_d[k] = d;
        end else begin : g_chain
            assign stage_d[k] = stage_q[k-1];
        end

        flip_flop_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk_i   (clk),
            .reset_i (reset),
            .d_i     (stage_d[k]),
            .q_o     (stage_q[k])
        );
    end

    assign q = stage_q[STAGES-1];

`ifdef FLIP_FLOP_ASSERT_EN
    if (STAGES < 1) begin : g_bad_stages
        $error("flip_flop: STAGES must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("flip_flop: WIDTH must be >= 1");
    end

    // Edges since the last reset edge, saturating at STAGES.
    int unsigned clean_q;
    logic        seen_reset_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            clean_q      <= '0;
            seen_reset_q <= 1'b1;
        end else if (clean_q < unsigned'(STAGES)) begin
            clean_q <= clean_q + 1;
        end
    end

    a_reset_value : assert property (@(posedge clk) reset |=> (q == RESET_VALUE));

    a_latency : assert property (@(posedge clk)
        ((seen_reset_q === 1'b1) && (clean_q >= unsigned'(STAGES))) |-> (q == $past(d, STAGES)));

    a_no_x : assert property (@(posedge clk) (seen_reset_q === 1'b1) |-> !$isunknown(q));
`endif

endmodule

// File: tb/tb_flip_flop.sv
// Self-checking bench: default 8-bit single-stage and 16-bit three-stage instances.
module tb_flip_flop;
    import flip_flop_pkg::*;

    typedef struct {
        logic       rst;
        logic [15:0] d;
    } hist_t;

    typedef struct {
        logic  rst;
        word_t d;
        word_t exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst8, rst16;
    word_t       d8, q8;
    logic [15:0] d16, q16;

    int checks   = 0;
    int failures = 0;

    hist_t h8[$];
    hist_t h16[$];

    always #5 clk = ~clk;

    flip_flop u_dut8 (
        .clk   (clk),
        .reset (rst8),
        .d     (d8),
        .q     (q8)
    );

    flip_flop #(
        .WIDTH       (16),
        .RESET_VALUE (16'hBEEF),
        .STAGES      (3)
    ) u_dut16 (
        .clk   (clk),
        .reset (rst16),
        .d     (d16),
        .q     (q16)
    );

    // Value q must hold after the latest edge: reset anywhere in the last s edges
    // gives the reset value, otherwise the d sampled s-1 edges ago.
    function automatic logic [15:0] model_q(input hist_t h[$], input int s, input logic [15:0] rv);
        for (int i = 0; i < s; i++) begin
            int idx = h.size() - 1 - i;
            if (idx < 0 || h[idx].rst) return rv;
        end
        return h[h.size() - s].d;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive both instances for one edge, then compare both against the model.
    task automatic step(input logic r8, input word_t v8, input logic r16, input logic [15:0] v16);
        hist_t e;
        rst8  = r8;
        d8    = v8;
        rst16 = r16;
        d16   = v16;
        @(posedge clk);
        e.rst = r8;  e.d = {8'h00, v8}; h8.push_back(e);
        e.rst = r16; e.d = v16;         h16.push_back(e);
        @(negedge clk);
        check("model8",  {8'h00, q8}, model_q(h8, 1, 16'h0000));
        check("model16", q16,         model_q(h16, 3, 16'hBEEF));
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        rst8 = 1'b1; rst16 = 1'b1; d8 = '0; d16 = '0;
        @(negedge clk);

        // Directed vectors for the default instance.
        v = '{1'b1, 8'hA5, 8'h00}; vecs.push_back(v);
        v = '{1'b0, 8'h3C, 8'h3C}; vecs.push_back(v);
        v = '{1'b0, 8'hFF, 8'hFF}; vecs.push_back(v);
        for (int unsigned i = 1; i <= 16; i++) begin
            v = '{1'b0, word_t'(i), word_t'(i)}; vecs.push_back(v);
        end
        v = '{1'b0, 8'h55, 8'h55}; vecs.push_back(v);
        v = '{1'b0, 8'hAA, 8'hAA}; vecs.push_back(v);
        v = '{1'b0, 8'h55, 8'h55}; vecs.push_back(v);
        v = '{1'b1, 8'hAA, 8'h00}; vecs.push_back(v);
        v = '{1'b0, 8'h55, 8'h55}; vecs.push_back(v);
        v = '{1'b0, 8'hAA, 8'hAA}; vecs.push_back(v);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].d, (i == 0), 16'(i));
            check($sformatf("vec%0d", i), {8'h00, q8}, {8'h00, vecs[i].exp});
        end

        // Three-stage instance: reset value, latency of 3, flush.
        step(1'b0, 8'h00, 1'b1, 16'hAAAA);
        check("p_reset", q16, 16'hBEEF);
        step(1'b0, 8'h00, 1'b0, 16'h1234);
        check("p_lat0", q16, 16'hBEEF);
        step(1'b0, 8'h00, 1'b0, 16'h0000);
        check("p_lat1", q16, 16'hBEEF);
        step(1'b0, 8'h00, 1'b0, 16'h0001);
        check("p_lat2", q16, 16'h1234);
        step(1'b0, 8'h00, 1'b0, 16'h0002);
        check("p_lat3", q16, 16'h0000);
        step(1'b0, 8'h00, 1'b1, 16'hDEAD);
        check("p_flush0", q16, 16'hBEEF);
        step(1'b0, 8'h00, 1'b0, 16'h7777);
        check("p_flush1", q16, 16'hBEEF);
        step(1'b0, 8'h00, 1'b0, 16'h8888);
        check("p_flush2", q16, 16'hBEEF);
        step(1'b0, 8'h00, 1'b0, 16'h9999);
        check("p_flush3", q16, 16'h7777);
        step(1'b0, 8'h00, 1'b0, 16'h0000);
        check("p_flush4", q16, 16'h8888);

        // Random traffic with occasional single-cycle resets.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(15) == 0), word_t'($urandom),
                 ($urandom_range(15) == 0), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
